// File: rtl/demux_pkg.sv
// ============================================================================
// Module      : demux_pkg
// Description : Shared sizing constants for the 1:4 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;
    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 8;
    localparam int DEF_WIDTH = 8;
endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module      : demux_slot
// Description : One output slot (valid + data) with optional handshake counter.
//               Counter enabled by macro DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
`ifdef DEMUX_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_done;

    assign w_done     = r_valid & ready;
    // A full slot can still take a beat when it drains in the same cycle.
    assign can_accept = ~r_valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d;
        end else if (w_done) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
`endif

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux_1_4_stream.sv
// ============================================================================
// Module      : demux_1_4_stream
// Description : 1:4 valid/ready stream demultiplexer, one register slot per
//               channel. Optional per-channel counters via DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [WIDTH-1:0]        d_in,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [NUM_CH*WIDTH-1:0] y_out,
    output logic [NUM_CH-1:0]       valid_out,
    input  logic [NUM_CH-1:0]       ready_in
`ifdef DEMUX_CNT_EN
    ,
    input  logic                    cnt_clr_in,
    output logic [NUM_CH*CNT_W-1:0] cnt_out
`endif
);

    logic [NUM_CH-1:0] w_can_accept;
    logic [NUM_CH-1:0] w_load;
    logic              w_accept;

    assign ready_out = w_can_accept[sel_in];
    assign w_accept  = valid_in & ready_out;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            assign w_load[k] = w_accept & (sel_in == SEL_W'(k));

            demux_slot #(
                .WIDTH      (WIDTH)
            ) u_slot (
                .clk        (clk_in),
                .rst_n      (rst_n_in),
                .load       (w_load[k]),
                .d          (d_in),
                .ready      (ready_in[k]),
                .valid      (valid_out[k]),
                .data       (y_out[k*WIDTH +: WIDTH]),
                .can_accept (w_can_accept[k])
`ifdef DEMUX_CNT_EN
                ,
                .cnt_clr    (cnt_clr_in),
                .cnt        (cnt_out[k*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule : demux_1_4_stream

`default_nettype wire
